// File: rtl/dec_ex_stage.sv
// ---------------------------------------------------------------------------
// dec_ex_stage
//   DEC/EX pipeline register of the 5-stage integer pipeline. It muxes the
//   forwarded operand values selected by the decode-stage forwarding unit into
//   the EX operands. It also contains the load-use interlock, which stalls
//   decode and injects bubbles until a load result can be forwarded from WB.
//
//   Optional feature: define DEC_EX_STALL_COUNT_EN to build the interlock
//   stall-cycle counter on StallCount. Without it, StallCount is tied to 0.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   DecValid..DecPC       decode-stage instruction fields
//   RegA, RegB            register-file read data
//   SrcA, SrcB            forwarding selects (00/01 RegOut, 10 MEM, 11 WB)
//   MEMValue, WBValue     forwarded result values
//   Flush                 kills the instruction entering EX, aborts interlock
//   MEMStall              freezes the whole pipe
//   StallDec              combinational hold request for fetch/decode
//   EXValid..EXPC         registered EX-stage instruction
//   StallCount            interlock stall-cycle counter
// ---------------------------------------------------------------------------
module dec_ex_stage #(
    parameter int WIDTH = 32,
    parameter int RW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             DecValid,
    input  logic [0:5]       DecOpCode,
    input  logic [0:5]       DecFunction,
    input  logic [0:RW-1]    DecRs1,
    input  logic [0:RW-1]    DecRs2,
    input  logic [0:RW-1]    DecRd,
    input  logic             DecUsesRs2,
    input  logic [0:WIDTH-1] DecPC,
    input  logic [0:WIDTH-1] RegA,
    input  logic [0:WIDTH-1] RegB,
    input  logic [0:1]       SrcA,
    input  logic [0:1]       SrcB,
    input  logic [0:WIDTH-1] MEMValue,
    input  logic [0:WIDTH-1] WBValue,
    input  logic             Flush,
    input  logic             MEMStall,
    output logic             StallDec,
    output logic             EXValid,
    output logic [0:5]       EXOpCode,
    output logic [0:5]       EXFunction,
    output logic [0:RW-1]    EXRd,
    output logic [0:WIDTH-1] EXOpA,
    output logic [0:WIDTH-1] EXOpB,
    output logic [0:WIDTH-1] EXPC,
    output logic [0:31]      StallCount
);

    localparam logic [0:5] NOP_FUNCTION = 6'h15;
    localparam logic [0:5] LOAD_FIRST   = 6'h20;
    localparam logic [0:5] LOAD_LAST    = 6'h27;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STALL1 = 2'd1,
        STALL2 = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic             ex_valid_reg;
    logic [0:5]       ex_opcode_reg;
    logic [0:5]       ex_function_reg;
    logic [0:RW-1]    ex_rd_reg;
    logic [0:WIDTH-1] ex_op_a_reg;
    logic [0:WIDTH-1] ex_op_b_reg;
    logic [0:WIDTH-1] ex_pc_reg;

    logic [0:WIDTH-1] op_a_next;
    logic [0:WIDTH-1] op_b_next;
    logic             ex_is_load;
    logic             hazard;
    logic             insert_bubble;
    logic             fsm_stall;

    // Select 01 is a don't-care from the forwarding unit; it behaves as RegOut.
    always_comb begin
        unique case (SrcA)
            2'b10:   op_a_next = MEMValue;
            2'b11:   op_a_next = WBValue;
            default: op_a_next = RegA;
        endcase
        unique case (SrcB)
            2'b10:   op_b_next = MEMValue;
            2'b11:   op_b_next = WBValue;
            default: op_b_next = RegB;
        endcase
    end

    assign ex_is_load = ex_valid_reg
                     && (ex_opcode_reg >= LOAD_FIRST)
                     && (ex_opcode_reg <= LOAD_LAST);

    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    // Non-load producers are covered by MEM forwarding and never stall.
    assign hazard = ex_is_load
                 && (ex_rd_reg != '0)
                 && DecValid
                 && ((DecRs1 == ex_rd_reg) || (DecUsesRs2 && (DecRs2 == ex_rd_reg)));

    // Interlock next-state logic. Flush and MEMStall override it in the
    // register process and in the StallDec equation below.
    always_comb begin
        state_next    = state_reg;
        insert_bubble = 1'b0;
        fsm_stall     = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (hazard) begin
                    state_next    = STALL1;
                    insert_bubble = 1'b1;
                    fsm_stall     = 1'b1;
                end
            end
            STALL1: begin
                state_next    = STALL2;
                insert_bubble = 1'b1;
                fsm_stall     = 1'b1;
            end
            STALL2: begin
                // The load is now in WB; the held decode instruction proceeds.
                state_next = IDLE;
            end
            default: begin
                state_next    = IDLE;
                insert_bubble = 1'b1;
            end
        endcase
    end

    assign StallDec = !rst && !Flush && (MEMStall || fsm_stall);

    always_ff @(posedge clk) begin
        if (rst || Flush) begin
            state_reg       <= IDLE;
            ex_valid_reg    <= 1'b0;
            ex_opcode_reg   <= '0;
            ex_function_reg <= NOP_FUNCTION;
            ex_rd_reg       <= '0;
            ex_op_a_reg     <= '0;
            ex_op_b_reg     <= '0;
            ex_pc_reg       <= '0;
        end else if (!MEMStall) begin
            state_reg <= state_next;
            if (insert_bubble) begin
                ex_valid_reg    <= 1'b0;
                ex_opcode_reg   <= '0;
                ex_function_reg <= NOP_FUNCTION;
                ex_rd_reg       <= '0;
                ex_op_a_reg     <= '0;
                ex_op_b_reg     <= '0;
                ex_pc_reg       <= '0;
            end else begin
                ex_valid_reg    <= DecValid;
                ex_opcode_reg   <= DecOpCode;
                ex_function_reg <= DecFunction;
                ex_rd_reg       <= DecRd;
                ex_op_a_reg     <= op_a_next;
                ex_op_b_reg     <= op_b_next;
                ex_pc_reg       <= DecPC;
            end
        end
    end

    assign EXValid    = ex_valid_reg;
    assign EXOpCode   = ex_opcode_reg;
    assign EXFunction = ex_function_reg;
    assign EXRd       = ex_rd_reg;
    assign EXOpA      = ex_op_a_reg;
    assign EXOpB      = ex_op_b_reg;
    assign EXPC       = ex_pc_reg;

`ifdef DEC_EX_STALL_COUNT_EN
    logic [0:31] stall_count_reg;
    logic        count_step;

    // Only cycles that actually advance the interlock are counted.
    assign count_step = fsm_stall && !Flush && !MEMStall;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_reg <= '0;
        end else if (count_step) begin
            stall_count_reg <= stall_count_reg + 32'd1;
        end
    end

    assign StallCount = stall_count_reg;
`else
    assign StallCount = '0;
`endif

endmodule

// File: tb/tb_dec_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_dec_ex_stage
//   Directed testbench for dec_ex_stage: reset state, operand forwarding,
//   load-use interlock, non-stalling cases, flush during a stall, MEMStall
//   during STALL2 and reset in the middle of a stall.
// ---------------------------------------------------------------------------
module tb_dec_ex_stage;

`ifdef DEC_EX_STALL_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        DecValid;
    logic [0:5]  DecOpCode;
    logic [0:5]  DecFunction;
    logic [0:5]  DecRs1;
    logic [0:5]  DecRs2;
    logic [0:5]  DecRd;
    logic        DecUsesRs2;
    logic [0:31] DecPC;
    logic [0:31] RegA;
    logic [0:31] RegB;
    logic [0:1]  SrcA;
    logic [0:1]  SrcB;
    logic [0:31] MEMValue;
    logic [0:31] WBValue;
    logic        Flush;
    logic        MEMStall;
    logic        StallDec;
    logic        EXValid;
    logic [0:5]  EXOpCode;
    logic [0:5]  EXFunction;
    logic [0:5]  EXRd;
    logic [0:31] EXOpA;
    logic [0:31] EXOpB;
    logic [0:31] EXPC;
    logic [0:31] StallCount;

    int total_checks = 0;
    int bad_checks   = 0;
    int exp_stalls   = 0;

    dec_ex_stage #(.WIDTH(32), .RW(6)) dut (
        .clk(clk), .rst(rst),
        .DecValid(DecValid), .DecOpCode(DecOpCode), .DecFunction(DecFunction),
        .DecRs1(DecRs1), .DecRs2(DecRs2), .DecRd(DecRd), .DecUsesRs2(DecUsesRs2),
        .DecPC(DecPC), .RegA(RegA), .RegB(RegB), .SrcA(SrcA), .SrcB(SrcB),
        .MEMValue(MEMValue), .WBValue(WBValue), .Flush(Flush), .MEMStall(MEMStall),
        .StallDec(StallDec), .EXValid(EXValid), .EXOpCode(EXOpCode),
        .EXFunction(EXFunction), .EXRd(EXRd), .EXOpA(EXOpA), .EXOpB(EXOpB),
        .EXPC(EXPC), .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_checks++;
        if (got !== exp) begin
            bad_checks++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(input logic [5:0] op, input logic [5:0] rs1, input logic [5:0] rs2,
                           input logic [5:0] rd, input logic uses2, input logic [31:0] pc);
        DecValid    = 1'b1;
        DecOpCode   = op;
        DecFunction = 6'h20;
        DecRs1      = rs1;
        DecRs2      = rs2;
        DecRd       = rd;
        DecUsesRs2  = uses2;
        DecPC       = pc;
    endtask

    task automatic check_bubble(input string tag);
        check_val({tag, ".valid"}, {31'd0, EXValid}, 32'd0);
        check_val({tag, ".op"},    {26'd0, EXOpCode}, 32'h00);
        check_val({tag, ".func"},  {26'd0, EXFunction}, 32'h15);
    endtask

    task automatic check_count(input string tag);
        check_val(tag, StallCount, CNT_EN ? 32'(exp_stalls) : 32'd0);
    endtask

    initial begin
        rst = 1'b1; Flush = 1'b0; MEMStall = 1'b0;
        DecValid = 1'b0; DecOpCode = '0; DecFunction = '0;
        DecRs1 = '0; DecRs2 = '0; DecRd = '0; DecUsesRs2 = 1'b0; DecPC = '0;
        RegA = 32'd5; RegB = 32'd6; MEMValue = 32'd9; WBValue = 32'd7;
        SrcA = 2'b00; SrcB = 2'b00;

        // Reset
        tick(); tick();
        check_bubble("reset");
        check_val("reset.rd", {26'd0, EXRd}, 32'd0);
        check_val("reset.stalldec", {31'd0, StallDec}, 32'd0);
        check_count("reset.count");
        rst = 1'b0;

        // Forwarding: MEM into A, WB into B
        set_dec(6'h00, 6'd1, 6'd2, 6'd4, 1'b1, 32'h100);
        SrcA = 2'b10; SrcB = 2'b11;
        tick();
        check_val("fwd.opa_mem", EXOpA, 32'd9);
        check_val("fwd.opb_wb", EXOpB, 32'd7);
        check_val("fwd.valid", {31'd0, EXValid}, 32'd1);
        check_val("fwd.rd", {26'd0, EXRd}, 32'd4);
        check_val("fwd.pc", EXPC, 32'h100);
        // Select 01 and 00 both take the register file
        SrcA = 2'b01; SrcB = 2'b00;
        tick();
        check_val("fwd.opa_01", EXOpA, 32'd5);
        check_val("fwd.opb_00", EXOpB, 32'd6);

        // Load-use: LW r3, then ADD using r3
        WBValue = 32'h77;
        set_dec(6'h23, 6'd1, 6'd0, 6'd3, 1'b0, 32'h104);
        tick();
        check_val("lu.lw_in_ex", {26'd0, EXOpCode}, 32'h23);
        set_dec(6'h00, 6'd3, 6'd2, 6'd5, 1'b1, 32'h108);
        #1;
        check_val("lu.stall_idle", {31'd0, StallDec}, 32'd1);
        tick(); exp_stalls++;
        check_bubble("lu.bubble1");
        check_val("lu.stall_s1", {31'd0, StallDec}, 32'd1);
        tick(); exp_stalls++;
        check_bubble("lu.bubble2");
        check_val("lu.stall_s2", {31'd0, StallDec}, 32'd0);
        SrcA = 2'b11;
        tick();
        check_val("lu.add_valid", {31'd0, EXValid}, 32'd1);
        check_val("lu.add_rd", {26'd0, EXRd}, 32'd5);
        check_val("lu.add_opa_wb", EXOpA, 32'h77);
        check_val("lu.add_pc", EXPC, 32'h108);
        check_count("lu.count");
        SrcA = 2'b00;

        // No stall: load targeting r0
        set_dec(6'h23, 6'd1, 6'd0, 6'd0, 1'b0, 32'h10c);
        tick();
        set_dec(6'h00, 6'd0, 6'd0, 6'd3, 1'b0, 32'h110);
        #1;
        check_val("nos.r0_stalldec", {31'd0, StallDec}, 32'd0);
        tick();
        check_val("nos.r0_valid", {31'd0, EXValid}, 32'd1);
        check_val("nos.r0_rd", {26'd0, EXRd}, 32'd3);
        // No stall: non-load producer of r3 in EX
        set_dec(6'h00, 6'd3, 6'd0, 6'd6, 1'b0, 32'h114);
        #1;
        check_val("nos.alu_stalldec", {31'd0, StallDec}, 32'd0);
        tick();
        check_val("nos.alu_rd", {26'd0, EXRd}, 32'd6);
        check_count("nos.count");

        // Flush while in STALL1 (hazard through Rs2)
        set_dec(6'h20, 6'd1, 6'd0, 6'd3, 1'b0, 32'h118);
        tick();
        set_dec(6'h00, 6'd1, 6'd3, 6'd7, 1'b1, 32'h11c);
        tick(); exp_stalls++;
        check_val("fl.stall_s1", {31'd0, StallDec}, 32'd1);
        Flush = 1'b1;
        #1;
        check_val("fl.stalldec_flush", {31'd0, StallDec}, 32'd0);
        tick();
        Flush = 1'b0;
        #1;
        check_bubble("fl.bubble");
        check_val("fl.idle_stalldec", {31'd0, StallDec}, 32'd0);
        tick();
        check_val("fl.add_valid", {31'd0, EXValid}, 32'd1);
        check_val("fl.add_rd", {26'd0, EXRd}, 32'd7);
        check_count("fl.count");

        // MEMStall held for 3 cycles in STALL2
        set_dec(6'h27, 6'd1, 6'd0, 6'd3, 1'b0, 32'h120);
        tick();
        set_dec(6'h00, 6'd3, 6'd0, 6'd8, 1'b0, 32'h124);
        tick(); exp_stalls++;
        tick(); exp_stalls++;
        check_val("ms.s2_stalldec", {31'd0, StallDec}, 32'd0);
        MEMStall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("ms.hold_stalldec", {31'd0, StallDec}, 32'd1);
            tick();
            check_bubble("ms.hold");
            check_count("ms.hold_count");
        end
        MEMStall = 1'b0;
        #1;
        check_val("ms.release_stalldec", {31'd0, StallDec}, 32'd0);
        tick();
        check_val("ms.add_valid", {31'd0, EXValid}, 32'd1);
        check_val("ms.add_rd", {26'd0, EXRd}, 32'd8);
        check_count("ms.count");

        // Reset in the middle of a stall
        set_dec(6'h23, 6'd1, 6'd0, 6'd3, 1'b0, 32'h128);
        tick();
        set_dec(6'h00, 6'd3, 6'd0, 6'd9, 1'b0, 32'h12c);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_stalls = 0;
        #1;
        check_bubble("rs.bubble");
        check_val("rs.stalldec", {31'd0, StallDec}, 32'd0);
        check_count("rs.count");

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule

// File: doc/dec_ex_stage.md
Name: dec_ex_stage

Overview:
- DEC/EX pipeline register of the 5-stage integer pipeline, directly downstream of the decode-stage forwarding unit.
- Consumes the 2-bit operand-source selects from the forwarding units and muxes RegOut, MEM or WB values into the EX operands.
- Contains the load-use interlock FSM: stalls decode and injects bubbles until a load result is forwardable from WB.
- Handles flush (branch redirect) and whole-pipe hold (MEM stall).

Parameters:
- WIDTH, 32, datapath width of operands and PC
- RW, 6, register-specifier width

Ports:
- clk  input  1  pipeline clock
- rst  input  1  synchronous active-high reset
- DecValid  input  1  decode holds a real instruction
- DecOpCode  input  [0:5]  decode opcode
- DecFunction  input  [0:5]  decode R-type function
- DecRs1, DecRs2, DecRd  input  [0:RW-1]  decode register specifiers
- DecUsesRs2  input  1  instruction reads Rs2
- DecPC  input  [0:WIDTH-1]  decode PC
- RegA, RegB  input  [0:WIDTH-1]  register-file read data
- SrcA, SrcB  input  [0:1]  forwarding selects: 00 RegOut, 01 don't-care (treat as RegOut), 10 MEM, 11 WB
- MEMValue, WBValue  input  [0:WIDTH-1]  forwarded values
- Flush  input  1  kill the instruction entering EX and abort the interlock
- MEMStall  input  1  freeze the whole pipe
- StallDec  output  1  hold fetch and decode this cycle
- EXValid  output  1  EX holds a real instruction
- EXOpCode, EXFunction  output  [0:5]
- EXRd  output  [0:RW-1]
- EXOpA, EXOpB, EXPC  output  [0:WIDTH-1]
- StallCount  output  [0:31]  interlock stall-cycle counter (optional feature)

Behaviour:
- Clock and reset: single clock `clk`; reset `rst` is synchronous and active-high.
- Bubble: EXValid=0, EXOpCode=6'h00, EXFunction=6'h15 (NOP), EXRd=0, EXOpA=EXOpB=EXPC=0.
- Reset: all EX outputs take the bubble value; FSM=IDLE; StallDec=0; StallCount=0.
- Operand mux (combinational, before the register): Src 10 selects MEMValue, 11 selects WBValue, 00 or 01 selects RegA/RegB.
- Load detect: EX holds a load when EXValid and 6'h20<=EXOpCode<=6'h27.
- Hazard condition: load in EX AND EXRd!=0 AND DecValid AND (DecRs1==EXRd OR (DecUsesRs2 AND DecRs2==EXRd)).
- Loads are forwardable only from WB, so a hazard costs 2 stall cycles.
- FSM:
  - IDLE: hazard -> STALL1; StallDec=1; a bubble is clocked into EX.
  - STALL1: -> STALL2; StallDec=1; bubble.
  - STALL2: -> IDLE; StallDec=0; the decode instruction is clocked in, with forwarding now selecting WB.
  - StallDec is combinational: asserted in IDLE when hazard is true, and in STALL1. It is deasserted in STALL2.
- In IDLE with no hazard: Dec fields and muxed operands are registered into EX; EXValid=DecValid.
- Priority each cycle: rst > Flush > MEMStall > FSM.
  - Flush: EX <= bubble, FSM <= IDLE, StallDec=0.
  - MEMStall (no Flush): EX registers and FSM hold; StallDec=1.
- MEMStall during STALL1/STALL2: the FSM does not advance. Stall-cycle counting is frozen too.
- Reset mid-stall returns to IDLE with a bubble in the next cycle.
- A hazard against Rd=0 never stalls.
- A non-load producer in EX never stalls; the forwarding path covers it.

Optional Feature:
- Macro DEC_EX_STALL_COUNT_EN.
- Defined: StallCount increments by 1 on every clock where the FSM is in IDLE-with-hazard or STALL1 and neither Flush nor MEMStall is asserted. It wraps modulo 2^32 and is cleared by rst.
- Undefined: no counter logic; StallCount is tied to 0.

Test Plan:
- Reset: rst=1 for 2 cycles -> EXValid=0, EXOpCode=00, EXFunction=15, StallDec=0, StallCount=0.
- Forwarding: DecValid=1, RegA=5, MEMValue=9, WBValue=7, SrcA=10, SrcB=11 -> next cycle EXOpA=9, EXOpB=7. With SrcA=01 -> EXOpA=5.
- Load-use: LW (op 23) with EXRd=3; decode ADD with Rs1=3 -> StallDec=1 for 2 cycles, 2 bubbles enter EX, ADD enters EX on the 3rd cycle, StallCount=2.
- No stall: LW EXRd=0 with DecRs1=0, or ADD EXRd=3 with DecRs1=3 -> StallDec=0, instruction passes in 1 cycle.
- Flush in STALL1 -> next cycle EX is a bubble, FSM=IDLE, StallDec=0.
- MEMStall held 3 cycles during STALL2 -> EX outputs and StallDec=1 held unchanged; on release the decode instruction enters EX in 1 cycle; StallCount unchanged during hold.
